exp_top: RTL and testbench

EXP_TOP -- requirements
Module: exp_top

---
 rtl/exp_top.sv | 85 ++++++++
 tb/tb_exp_top.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/exp_top.sv
// exp_top: exp(x) for unsigned Q0.16 x by Maclaurin series. One term is computed per cycle. Define EXP_TOP_ROUND_EN to round the result half-up.
// Latency: done is high NTERMS+1 cycles after the edge that samples start. rBus holds its value between done pulses.
// No backpressure. start is sampled only in IDLE, and start and xBus are ignored while a computation runs.
module exp_top #(
    parameter int NTERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] xBus,
    output logic [17:0] rBus,
    output logic        done
);
    localparam int KW = $clog2(NTERMS + 1);
    localparam logic [25:0] ONE = 26'h100_0000;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [23:0]   x;
    logic [25:0]   term;
    logic [25:0]   sum;
    logic [KW-1:0] k;

    // Entry k of the ROM holds round(2^24/k).
    // Entry 1 holds exactly 1.0, so the ROM is one bit wider than Q0.24.
    logic [24:0] recip_rom [NTERMS+1];
    for (genvar g = 0; g <= NTERMS; g++) begin : g_rom
        if (g == 0) begin : g_zero
            assign recip_rom[g] = '0;
        end else begin : g_k
            assign recip_rom[g] = 25'(((1 << 24) + g / 2) / g);
        end
    end

    logic [25:0] px_hi;
    logic [25:0] term_nx;
    logic [17:0] r_nx;

    assign px_hi   = 26'((50'(term) * 50'(x)) >> 24);
    assign term_nx = 26'((51'(px_hi) * 51'(recip_rom[k])) >> 24);

`ifdef EXP_TOP_ROUND_EN
    assign r_nx = sum[25:8] + 18'(sum[7]);
`else
    assign r_nx = sum[25:8];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            term  <= '0;
            sum   <= '0;
            k     <= '0;
            rBus  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= {xBus, 8'h00};
                        term  <= ONE;
                        sum   <= ONE;
                        k     <= KW'(1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    term <= term_nx;
                    sum  <= sum + term_nx;
                    k    <= k + 1'b1;
                    if (k == KW'(NTERMS)) state <= DONE;
                end
                DONE: begin
                    rBus  <= r_nx;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_top.sv
// Scoreboard bench for exp_top. Each launch pushes its operand and expected done cycle.
// A monitor compares every done pulse against real-valued exp(x).
module tb_exp_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] xBus = '0;
    logic [17:0] rBus;
    logic        done;

    exp_top #(.NTERMS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .xBus  (xBus),
        .rBus  (rBus),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rst_q = 1'b0;
    logic        done_q = 1'b0;
    logic [17:0] last_r = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        real  ref_v;
        real  d;
        if (cyc >= 1) begin
            if (rst_q) begin
                checks++;
                if (rBus !== 18'h0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: rBus=%h done=%b, required rBus=00000 done=0", rBus, done);
                end
                last_r = '0;
            end else if (done === 1'b1) begin
                checks++;
                if (done_q === 1'b1) begin
                    errors++;
                    $display("FAIL done_width: done high in consecutive cycles at cycle %0d", cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: done at cycle %0d with no launch pending", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL latency x=%h: done at cycle %0d, required %0d", e.x, cyc, e.due);
                    end
                    ref_v = $exp(real'(e.x) / 65536.0) * 65536.0;
                    d = real'(rBus) - ref_v;
                    checks++;
                    if (e.x == 16'h0000) begin
                        if (rBus !== 18'h10000) begin
                            errors++;
                            $display("FAIL exp_zero: rBus=%h, required 10000", rBus);
                        end
                    end else if (d < -2.0 || d > 2.0) begin
                        errors++;
                        $display("FAIL exp_value x=%h: rBus=%h, required %f +-2", e.x, rBus, ref_v);
                    end
                end
                last_r = rBus;
            end else begin
                checks++;
                if (rBus !== last_r) begin
                    errors++;
                    $display("FAIL rbus_hold: rBus=%h at cycle %0d, required %h", rBus, cyc, last_r);
                end
            end
            done_q = done;
        end
    end

    task automatic push_exp(input logic [15:0] xv, input int due);
        exp_t e;
        e.x   = xv;
        e.due = due;
        sb.push_back(e);
    endtask

    // Launch one computation. The task returns at the negedge where done is visible.
    task automatic launch(input logic [15:0] xv, input bit scramble);
        xBus  = xv;
        start = 1'b1;
        push_exp(xv, cyc + 10);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (scramble) xBus = 16'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        int c;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        launch(16'h0000, 1'b0);
        launch(16'h8000, 1'b1);
        launch(16'hFFFF, 1'b1);

        // Hold start high and launch back-to-back. The second operand is applied after the first done.
        c     = cyc;
        xBus  = 16'h4000;
        start = 1'b1;
        push_exp(16'h4000, c + 10);
        push_exp(16'hC000, c + 20);
        repeat (10) @(negedge clk);
        xBus = 16'hC000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);

        // Assert reset mid-computation. The launch must be aborted without a done pulse.
        xBus  = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 256; i++) launch(16'(i * 257), i[0]);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(16'($urandom), 1'b1);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results: %0d launches without done, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
